// File: rtl/disp_filter_pkg.sv
// disp_filter_pkg
// Shared types and width helpers for the weighted disparity filter.
//   dc_sum_w(db, wl) : width of the sum(disp*conf) accumulator
//   c_sum_w(wl)      : width of the sum(conf) accumulator
//   wdf_state_t      : divider-control FSM states
package disp_filter_pkg;

    function automatic int dc_sum_w(input int db, input int wl);
        return 8 + db + $clog2(wl);
    endfunction

    function automatic int c_sum_w(input int wl);
        return 8 + $clog2(wl);
    endfunction

    typedef enum logic [1:0] {IDLE, DIV, DONE} wdf_state_t;

endpackage

// File: rtl/serial_divider.sv
// serial_divider
// Bit-serial restoring divider, one quotient bit per cycle, MSB first.
// Fixed latency of quotient_w cycles after start.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : load dividend/divisor (ignored while busy)
//   dividend        : dividend_w-bit numerator
//   divisor         : divisor_w-bit denominator
//   busy            : division in progress
//   done            : high in the cycle whose edge produces the last bit;
//                     quotient is final after that edge
//   quotient        : quotient_w-bit result (truncated)
// The caller guarantees dividend < divisor * 2**quotient_w, so only
// quotient_w restoring steps are needed.
module serial_divider #(
    parameter int dividend_w = 16,
    parameter int divisor_w  = 11,
    parameter int quotient_w = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [dividend_w-1:0] dividend,
    input  logic [divisor_w-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [quotient_w-1:0] quotient
);

    localparam int W  = (dividend_w > divisor_w + quotient_w) ? dividend_w
                                                              : divisor_w + quotient_w;
    localparam int CW = $clog2(quotient_w + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  dsh;    // divisor aligned to the current quotient bit
    logic [CW-1:0] cnt;
    logic          q_bit;

    assign q_bit = (rem >= dsh);
    assign done  = busy && (cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            dsh      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start && !busy) begin
            rem      <= W'(dividend);
            dsh      <= W'(divisor) << (quotient_w - 1);
            cnt      <= CW'(quotient_w);
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            if (q_bit)
                rem <= rem - dsh;
            quotient <= quotient_w'({quotient, q_bit});
            dsh      <= dsh >> 1;
            cnt      <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/weighted_disp_filter.sv
// weighted_disp_filter
// Accumulates win_len valid samples along a row and emits one
// confidence-weighted disparity sum(disp*conf)/sum(conf) per window,
// plus the window mean confidence sum(conf)>>log2(win_len).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   disp_conf_in  : disp*conf product from upstream
//   conf_in       : per-sample confidence
//   in_valid      : sample strobe
//   line_start    : first sample of a row; restarts the window
//   disp_out      : weighted disparity (held until next result)
//   conf_out      : mean confidence (held until next result)
//   out_valid     : one-cycle pulse per completed window
//   overflow      : sticky; window completed while divider was busy
// Optional: `define WEIGHTED_DISP_HOLD_EN makes a zero-confidence window
// repeat the last valid disparity instead of reporting 0.
module weighted_disp_filter
    import disp_filter_pkg::*;
#(
    parameter int disp_bits = 5,
    parameter int win_len   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8+disp_bits-1:0] disp_conf_in,
    input  logic [7:0]             conf_in,
    input  logic                   in_valid,
    input  logic                   line_start,
    output logic [disp_bits-1:0]   disp_out,
    output logic [7:0]             conf_out,
    output logic                   out_valid,
    output logic                   overflow
);

    localparam int DCW = dc_sum_w(disp_bits, win_len);
    localparam int CSW = c_sum_w(win_len);
    localparam int LW  = $clog2(win_len);

    if ((win_len < disp_bits + 2) || ((win_len & (win_len - 1)) != 0)) begin : g_param_check
        $error("weighted_disp_filter: win_len must be a power of two >= disp_bits+2");
    end

    logic [DCW-1:0]       sum_dc;
    logic [CSW-1:0]       sum_c;
    logic [LW-1:0]        cnt;
    logic [DCW-1:0]       final_dc;
    logic [CSW-1:0]       final_c;
    logic                 complete;
    logic                 start_div;
    logic [7:0]           conf_mean;
    logic                 c_zero;
    logic                 div_busy;
    logic                 div_done;
    logic [disp_bits-1:0] div_q;
    wdf_state_t           state, next_state;

    // Sums including the current sample, used on the completing edge.
    assign final_dc  = sum_dc + DCW'(disp_conf_in);
    assign final_c   = sum_c + CSW'(conf_in);
    assign complete  = in_valid && !line_start && (cnt == LW'(win_len - 1));
    assign start_div = complete && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_dc <= '0;
            sum_c  <= '0;
            cnt    <= '0;
        end else if (in_valid) begin
            if (line_start) begin
                sum_dc <= DCW'(disp_conf_in);
                sum_c  <= CSW'(conf_in);
                cnt    <= LW'(1);
            end else if (complete) begin
                sum_dc <= '0;
                sum_c  <= '0;
                cnt    <= '0;
            end else begin
                sum_dc <= final_dc;
                sum_c  <= final_c;
                cnt    <= cnt + LW'(1);
            end
        end else if (line_start) begin
            sum_dc <= '0;
            sum_c  <= '0;
            cnt    <= '0;
        end
    end

    // The divider runs even for a zero divisor so the latency stays fixed;
    // its result is simply ignored in that case.
    serial_divider #(
        .dividend_w (DCW),
        .divisor_w  (CSW),
        .quotient_w (disp_bits)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (start_div),
        .dividend (final_dc),
        .divisor  (final_c),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_div) next_state = DIV;
            DIV:     if (div_done)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conf_mean <= '0;
            c_zero    <= 1'b0;
            disp_out  <= '0;
            conf_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            if (complete && state != IDLE)
                overflow <= 1'b1;
            if (start_div) begin
                conf_mean <= final_c[CSW-1:LW];
                c_zero    <= (final_c == '0);
            end
            if (state == DONE) begin
                conf_out <= c_zero ? 8'd0 : conf_mean;
`ifdef WEIGHTED_DISP_HOLD_EN
                if (!c_zero)
                    disp_out <= div_q;
`else
                disp_out <= c_zero ? '0 : div_q;
`endif
            end
        end
    end

endmodule
